// File: rtl/seg_pkg.sv
// Shared constants, output bundle and BCD helper for the display scanner.
package seg_pkg;

  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam int         DIGITS = 4;

  typedef struct packed {
    logic [3:0] bcd;
    logic       blank;
    logic       dp;
    logic [3:0] an_n;
    logic       frame_done;
  } scan_out_t;

  localparam scan_out_t OUT_RST = '{bcd: 4'd0, blank: 1'b1, dp: 1'b0,
                                    an_n: AN_OFF, frame_done: 1'b0};

  function automatic logic bcd_valid(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_prescaler.sv
// Terminal-count divider: tick_o on the last cycle of each slot,
// slot_start_o on the first (dead-time) cycle.
module scan_prescaler #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o,
  output logic slot_start_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o       = (cnt_q == W'(DIV - 1));
  assign slot_start_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed BCD display scanner with dead time, frame-atomic
// updates and optional leading-zero blanking. All outputs are registered.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  bcd_out,
  output logic        blank,
  output logic        dp_out,
  output logic [3:0]  an_n,
  output logic        frame_done
);

  logic        tick;
  logic        slot_start;
  logic        frame_wrap;

  logic [1:0]  idx_q, idx_d;
  logic [15:0] pend_val_q, pend_val_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic [15:0] disp_val_q, disp_val_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  scan_out_t   out_q, out_d;

  logic [3:0]        digit;
  logic [DIGITS-1:0] zero_from;
  logic              lz_blank;

  scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
    .clk          (clk),
    .rst          (rst),
    .tick_o       (tick),
    .slot_start_o (slot_start)
  );

  assign frame_wrap = tick && (idx_q == 2'd3);

  // zero_from[i]: digit i and every more significant digit are zero
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero_from
      assign zero_from[gi] = ~|disp_val_q[15:4*gi];
    end
  endgenerate

  assign digit    = disp_val_q[4*idx_q +: 4];
  assign lz_blank = blank_lz && (idx_q != 2'd0) && zero_from[idx_q];

  always_comb begin
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    pend_val_d = load ? value_in : pend_val_q;
    pend_dp_d  = load ? dp_in    : pend_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    // A load coinciding with the wrap bypasses the pending registers
    if (frame_wrap) begin
      disp_val_d = load ? value_in : pend_val_q;
      disp_dp_d  = load ? dp_in    : pend_dp_q;
    end
  end

  always_comb begin
    out_d.bcd        = digit;
    out_d.blank      = !bcd_valid(digit) || lz_blank;
    out_d.dp         = disp_dp_q[idx_q];
    out_d.an_n       = slot_start ? AN_OFF : ~(4'b0001 << idx_q);
    out_d.frame_done = frame_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= 2'd0;
      pend_val_q <= 16'd0;
      pend_dp_q  <= 4'd0;
      disp_val_q <= 16'd0;
      disp_dp_q  <= 4'd0;
      out_q      <= OUT_RST;
    end else begin
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      out_q      <= out_d;
    end
  end

  assign bcd_out    = out_q.bcd;
  assign blank      = out_q.blank;
  assign dp_out     = out_q.dp;
  assign an_n       = out_q.an_n;
  assign frame_done = out_q.frame_done;

endmodule
